// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the dmem port. It keeps one transaction outstanding and drives dmem requests from registers.
// Latency: grant is combinational in IDLE, the request leaves one cycle later, and rvalid passes through in the cycle it arrives.
// Backpressure: REQ holds until data_gnt_i, no grant is given while busy; optional rvalid timeout under DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_be,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_be,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dmem_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q;
  logic        grant_vld;
  logic        grant_id;
  logic        resp_vld;
  logic        resp_err;
  logic [31:0] resp_dat;
  logic        timeout;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  // The compare is against TIMEOUT_CYCLES-1 because the count excludes the current WAIT cycle.
  assign timeout = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != WAIT) begin
      wait_cnt_q <= '0;
    end else if (!data_rvalid_i) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    resp_vld  = 1'b0;
    resp_err  = 1'b0;
    resp_dat  = 32'h0;
    case (state_q)
      IDLE: begin
        if (i_m0_req || i_m1_req) begin
          grant_vld = 1'b1;
          grant_id  = (i_m0_req && i_m1_req) ? ptr_q : i_m1_req;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        // A real response wins over a timeout that fires in the same cycle.
        if (data_rvalid_i) begin
          resp_vld = 1'b1;
          resp_err = data_err_i;
          resp_dat = data_rdata_i;
        end else if (timeout) begin
          resp_vld = 1'b1;
          resp_err = 1'b1;
        end
        if (resp_vld) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'h0;
      data_addr_o  <= 32'h0;
      data_wdata_o <= 32'h0;
      owner_q      <= 1'b0;
    end else if (grant_vld) begin
      data_req_o   <= 1'b1;
      owner_q      <= grant_id;
      data_we_o    <= grant_id ? i_m1_we    : i_m0_we;
      data_be_o    <= grant_id ? i_m1_be    : i_m0_be;
      data_addr_o  <= grant_id ? i_m1_addr  : i_m0_addr;
      data_wdata_o <= grant_id ? i_m1_wdata : i_m0_wdata;
    end else if (state_q == REQ && data_gnt_i) begin
      data_req_o <= 1'b0;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks from a stale state.
  assign o_m0_gnt    = !i_rst && grant_vld && !grant_id;
  assign o_m1_gnt    = !i_rst && grant_vld &&  grant_id;
  assign o_m0_rvalid = !i_rst && resp_vld  && !owner_q;
  assign o_m1_rvalid = !i_rst && resp_vld  &&  owner_q;
  assign o_m0_err    = o_m0_rvalid && resp_err;
  assign o_m1_err    = o_m1_rvalid && resp_err;
  assign o_m0_rdata  = o_m0_rvalid ? resp_dat : 32'h0;
  assign o_m1_rdata  = o_m1_rvalid ? resp_dat : 32'h0;

endmodule
